// File: rtl/ascii_operand_loader.sv
// ASCII decimal operand loader: assembles an X/Y operand pair from a byte stream for the adder stage.
// Optional ASCII_LOADER_CR_EN: CR also terminates an operand, and an LF right after a CR is dropped.
module ascii_operand_loader #(
    parameter int OP_W       = 5,
    parameter int MAX_DIGITS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            char_valid,
    input  logic [7:0]      char_data,
    output logic            char_ready,
    output logic [OP_W-1:0] op_x,
    output logic [OP_W-1:0] op_y,
    output logic            op_valid,
    input  logic            op_ready,
    output logic            err,
    output logic [1:0]      err_code
);

    localparam int ACC_W = $clog2(10 ** MAX_DIGITS);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'((1 << OP_W) - 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [1:0] {GET_X, GET_Y, HOLD, SKIP} state_t;
    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_CHAR   = 2'b01,
        ERR_DIGITS = 2'b10,
        ERR_VALUE  = 2'b11
    } err_t;

    state_t           state, state_next;
    err_t             err_kind;
    logic [ACC_W-1:0] acc, acc_mac;
    logic [CNT_W-1:0] count;
    logic             accept, is_digit, is_term, drop_lf, digit_hit, term_ok;

    assign accept   = char_valid && char_ready;
    assign is_digit = (char_data >= 8'h30) && (char_data <= 8'h39);
    // acc*10 + digit; only reached while count < MAX_DIGITS, so it never overflows ACC_W
    assign acc_mac  = (acc << 3) + (acc << 1) + ACC_W'(char_data[3:0]);

`ifdef ASCII_LOADER_CR_EN
    localparam logic [7:0] CR = 8'h0D;
    logic cr_seen;

    assign is_term = (char_data == LF) || (char_data == CR);
    assign drop_lf = cr_seen && (char_data == LF);

    // Remembers whether the previously accepted byte was a CR, across HOLD if needed
    always_ff @(posedge clk) begin
        if (!rst_n)      cr_seen <= 1'b0;
        else if (accept) cr_seen <= (char_data == CR);
    end
`else
    assign is_term = (char_data == LF);
    assign drop_lf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= GET_X;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        err_kind   = ERR_NONE;
        digit_hit  = 1'b0;
        term_ok    = 1'b0;
        unique case (state)
            GET_X, GET_Y: begin
                if (accept && !drop_lf) begin
                    if (is_digit) begin
                        if (count == MAX_CNT) begin
                            err_kind   = ERR_DIGITS;
                            state_next = SKIP;
                        end else begin
                            digit_hit = 1'b1;
                        end
                    end else if (is_term) begin
                        if (count == '0 || acc > MAX_VAL) begin
                            err_kind   = ERR_VALUE;
                            state_next = GET_X;
                        end else begin
                            term_ok    = 1'b1;
                            state_next = (state == GET_X) ? GET_Y : HOLD;
                        end
                    end else begin
                        err_kind   = ERR_CHAR;
                        state_next = SKIP;
                    end
                end
            end
            HOLD:    if (op_ready) state_next = GET_X;
            SKIP:    if (accept && is_term) state_next = GET_X;
            default: state_next = GET_X;
        endcase
    end

    always_comb begin
        char_ready = (state != HOLD);
        op_valid   = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            count    <= '0;
            op_x     <= '0;
            op_y     <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            err <= (err_kind != ERR_NONE);
            if (err_kind != ERR_NONE) err_code <= err_kind;

            // Any accepted non-accumulating byte ends or aborts the operand
            if (digit_hit) begin
                acc   <= acc_mac;
                count <= count + CNT_W'(1);
            end else if (accept) begin
                acc   <= '0;
                count <= '0;
            end

            if (term_ok && state == GET_X) op_x <= acc[OP_W-1:0];
            if (term_ok && state == GET_Y) op_y <= acc[OP_W-1:0];
        end
    end

endmodule

// File: tb/tb_ascii_operand_loader.sv
// Self-checking bench for ascii_operand_loader: directed streams plus random token streams
// compared against a line-parsing reference model (honours ASCII_LOADER_CR_EN).
module tb_ascii_operand_loader;

    localparam int OP_W = 5;
`ifdef ASCII_LOADER_CR_EN
    localparam bit CR_EN = 1'b1;
`else
    localparam bit CR_EN = 1'b0;
`endif

    typedef struct { int x; int y; } pair_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            char_valid = 1'b0;
    logic [7:0]      char_data = 8'h00;
    logic            char_ready;
    logic [OP_W-1:0] op_x, op_y;
    logic            op_valid;
    logic            op_ready = 1'b0;
    logic            err;
    logic [1:0]      err_code;

    ascii_operand_loader #(.OP_W(OP_W), .MAX_DIGITS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .op_x       (op_x),
        .op_y       (op_y),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] stream[$];
    pair_t      pairs[$];
    bit         exp_err = 1'b0;
    bit         exp_valid = 1'b0;
    logic [1:0] exp_code = 2'b00;

    // Reference model: 0 = reading X, 1 = reading Y, 2 = skipping to end of line
    int m_mode = 0, m_ndig = 0, m_val = 0, m_px = 0;
    bit m_cr = 1'b0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ndig = 0; m_val = 0; m_px = 0; m_cr = 1'b0;
        exp_err = 1'b0; exp_valid = 1'b0; exp_code = 2'b00;
        stream.delete();
        pairs.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, output bit e, output logic [1:0] code, output bit pushed);
        bit term;
        e = 1'b0; code = 2'b00; pushed = 1'b0;
        if (CR_EN && m_cr && b == 8'h0A) begin
            m_cr = 1'b0;
            return;
        end
        m_cr = CR_EN && (b == 8'h0D);
        term = (b == 8'h0A) || (CR_EN && b == 8'h0D);
        if (m_mode == 2) begin
            if (term) m_mode = 0;
            return;
        end
        if (b >= "0" && b <= "9") begin
            if (m_ndig == 2) begin
                e = 1'b1; code = 2'b10; m_mode = 2; m_ndig = 0; m_val = 0;
            end else begin
                m_ndig++;
                m_val = m_val * 10 + int'(b) - 48;
            end
        end else if (term) begin
            if (m_ndig == 0 || m_val > 2 ** OP_W - 1) begin
                e = 1'b1; code = 2'b11; m_mode = 0;
            end else if (m_mode == 0) begin
                m_px = m_val; m_mode = 1;
            end else begin
                pairs.push_back('{x: m_px, y: m_val});
                pushed = 1'b1; m_mode = 0;
            end
            m_ndig = 0; m_val = 0;
        end else begin
            e = 1'b1; code = 2'b01; m_mode = 2; m_ndig = 0; m_val = 0;
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) stream.push_back(s[i]);
    endtask

    task automatic push_num(input int v);
        if (v >= 10) stream.push_back(8'(48 + v / 10));
        stream.push_back(8'(48 + v % 10));
    endtask

    // One clock: check what the last edge produced, then drive and predict the next edge
    task automatic cycle(input int vpct, input int rpct);
        bit         e, pushed;
        logic [1:0] code;
        pair_t      p;
        @(negedge clk);
        check("err", err, exp_err);
        check("err_code", err_code, exp_code);
        check("op_valid", op_valid, exp_valid);
        check("char_ready", char_ready, !exp_valid);

        char_valid = (stream.size() != 0) && ($urandom_range(99) < vpct);
        char_data  = char_valid ? stream[0] : 8'($urandom);
        op_ready   = ($urandom_range(99) < rpct);

        exp_err = 1'b0;
        if (char_valid && char_ready) begin
            model_byte(stream.pop_front(), e, code, pushed);
            exp_err = e;
            if (e) exp_code = code;
            if (pushed) exp_valid = 1'b1;
        end
        if (op_valid && op_ready) begin
            check("pair_expected", pairs.size(), (pairs.size() == 0) ? 1 : pairs.size());
            if (pairs.size() != 0) begin
                p = pairs.pop_front();
                check("op_x", op_x, p.x);
                check("op_y", op_y, p.y);
            end
            exp_valid = 1'b0;
        end
    endtask

    task automatic run_drain(input int vpct, input int rpct);
        int n = 0;
        while ((stream.size() != 0 || pairs.size() != 0 || exp_valid) && n < 4000) begin
            cycle(vpct, rpct);
            n++;
        end
        repeat (2) cycle(vpct, rpct);
        check("drain", stream.size() + pairs.size() + int'(exp_valid), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; char_valid = 1'b0; op_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_op_x", op_x, 0);
        check("rst_op_y", op_y, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_char_ready", char_ready, 1);
        model_reset();
    endtask

    task automatic gen_token();
        logic [7:0] junk[5];
        int k;
        junk = '{8'h61, 8'h20, 8'h2F, 8'h3A, 8'h0D};
        k = $urandom_range(9);
        case (k)
            0, 1, 2, 3: begin
                int v = $urandom_range(2 ** OP_W - 1);
                if (v < 10 && $urandom_range(1) == 1) push_str("0");
                push_num(v);
                if ($urandom_range(4) == 0) stream.push_back(8'h0D);
                push_str("\n");
            end
            4: begin push_num($urandom_range(99, 2 ** OP_W)); push_str("\n"); end
            5: begin
                repeat (3) stream.push_back(8'(48 + $urandom_range(9)));
                push_str("\n");
            end
            6: push_str("\n");
            7: begin
                push_num($urandom_range(9));
                stream.push_back(junk[$urandom_range(4)]);
                push_str("\n");
            end
            8: begin push_num($urandom_range(31)); stream.push_back(8'h0D); end
            default: begin
                push_num($urandom_range(31)); push_str("\n");
                push_num($urandom_range(31)); push_str("\n");
            end
        endcase
    endtask

    initial begin
        do_reset();

        // Plain pair, downstream always ready
        push_str("12\n07\n");
        run_drain(100, 100);

        // Backpressure: pair must hold stable with char_ready low
        push_str("31\n31\n");
        for (int i = 0; i < 50 && !op_valid; i++) cycle(100, 0);
        check("hold_valid", op_valid, 1);
        repeat (5) begin
            cycle(100, 0);
            check("hold_op_x", op_x, 31);
            check("hold_op_y", op_y, 31);
            check("hold_char_ready", char_ready, 0);
        end
        run_drain(100, 100);

        // Error classes and resynchronisation
        push_str("4a\n3\n5\n");
        run_drain(100, 100);
        push_str("123\n45\n\n00\n9\n");
        run_drain(100, 100);

        // Reset in the middle of Y, then a fresh pair
        push_str("12\n1");
        for (int i = 0; i < 20 && stream.size() != 0; i++) cycle(100, 100);
        do_reset();
        push_str("2\n3\n");
        run_drain(100, 100);

        // DOS line endings: one terminator with CR enabled, a non-digit otherwise
        push_str("9"); stream.push_back(8'h0D); push_str("\n");
        push_str("8"); stream.push_back(8'h0D); push_str("\n");
        push_str("6\n1\n");
        run_drain(100, 100);

        // Random token streams with random valid/ready gaps
        for (int r = 0; r < 6; r++) begin
            repeat (50) gen_token();
            push_str("\n1\n2\n");
            run_drain(70, 60);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
